// File: rtl/data_merge.sv
//----------------------------------------------------------------------------
// data_merge : recombines a two-lane alternating word stream into one ordered
//              stream through per-lane FIFOs.
// Revision   : 1.0
//----------------------------------------------------------------------------
`default_nettype none

module data_merge #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [7:0]  max,
    input  logic [16:0] data_in0,
    input  logic [16:0] data_in1,
    output logic [15:0] data_out,
    output logic        valid_out,
    output logic        done,
    output logic        err
);

    localparam int c_PW = $clog2(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            r_state;
    logic              r_sel;
    logic [7:0]        r_cnt;
    logic [7:0]        r_max;
    logic [7:0]        w_cnt_nxt;
    logic              w_run;
    logic [1:0][16:0]  w_din;
    logic [1:0]        w_push;
    logic [1:0]        w_pop;
    logic [1:0]        w_drop;
    logic [1:0]        w_empty;
    logic [1:0]        w_full;
    logic [1:0][15:0]  w_head;

    assign w_din     = {data_in1, data_in0};
    assign w_cnt_nxt = r_cnt + 8'd1;
    // A start pulse overrides all FIFO traffic in its cycle.
    assign w_run     = (r_state == S_RUN) && !start;

    for (genvar g = 0; g < 2; g++) begin : g_lane
        logic [15:0]   r_mem [DEPTH];
        logic [c_PW:0] r_wr;
        logic [c_PW:0] r_rd;

        assign w_empty[g] = (r_wr == r_rd);
        assign w_full[g]  = (r_wr[c_PW] != r_rd[c_PW]) &&
                            (r_wr[c_PW-1:0] == r_rd[c_PW-1:0]);
        assign w_head[g]  = r_mem[r_rd[c_PW-1:0]];
        // Pop decision uses registered occupancy, so a same-cycle push never bypasses.
        assign w_pop[g]   = w_run && (r_sel == 1'(g)) && !w_empty[g];
        assign w_push[g]  = w_run && w_din[g][16] && (!w_full[g] || w_pop[g]);
        assign w_drop[g]  = w_run && w_din[g][16] && w_full[g] && !w_pop[g];

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                r_wr <= '0;
                r_rd <= '0;
            end else if (start) begin
                r_wr <= '0;
                r_rd <= '0;
            end else begin
                if (w_push[g]) r_wr <= r_wr + 1'b1;
                if (w_pop[g])  r_rd <= r_rd + 1'b1;
            end
        end

        always_ff @(posedge clk) begin
            if (w_push[g]) r_mem[r_wr[c_PW-1:0]] <= w_din[g][15:0];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= S_IDLE;
            r_sel     <= 1'b0;
            r_cnt     <= 8'd0;
            r_max     <= 8'd0;
            data_out  <= 16'd0;
            valid_out <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else if (start) begin
            r_max     <= max;
            r_cnt     <= 8'd0;
            r_sel     <= 1'b0;
            data_out  <= 16'd0;
            valid_out <= 1'b0;
            err       <= 1'b0;
            if (max == 8'd0) begin
                r_state <= S_DONE;
                done    <= 1'b1;
            end else begin
                r_state <= S_RUN;
                done    <= 1'b0;
            end
        end else begin
            data_out  <= 16'd0;
            valid_out <= 1'b0;
            if (|w_drop) err <= 1'b1;
            if (|w_pop) begin
                data_out  <= w_head[r_sel];
                valid_out <= 1'b1;
                r_sel     <= ~r_sel;
                r_cnt     <= w_cnt_nxt;
                if (w_cnt_nxt == r_max) begin
                    r_state <= S_DONE;
                    done    <= 1'b1;
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_data_merge.sv
//----------------------------------------------------------------------------
// tb_data_merge : scoreboard bench for data_merge with a queue-based model.
// Revision      : 1.0
//----------------------------------------------------------------------------
`default_nettype none

module tb_data_merge;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  max = 8'd0;
    logic [16:0] data_in0 = 17'd0;
    logic [16:0] data_in1 = 17'd0;
    logic [15:0] data_out;
    logic        valid_out;
    logic        done;
    logic        err;

    always #5 clk = ~clk;

    data_merge #(.DEPTH(DEPTH)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (start),
        .max       (max),
        .data_in0  (data_in0),
        .data_in1  (data_in1),
        .data_out  (data_out),
        .valid_out (valid_out),
        .done      (done),
        .err       (err)
    );

    typedef struct {
        logic [15:0] data;
        logic        done;
    } exp_t;

    int          n_checks = 0;
    int          n_fail   = 0;
    exp_t        exp_q[$];
    exp_t        mon_e;
    logic [15:0] q0[$];
    logic [15:0] q1[$];
    int          m_state = 0;   // 0 idle, 1 run, 2 done
    int          m_sel   = 0;
    int          m_cnt   = 0;
    int          m_max   = 0;
    logic        m_done  = 1'b0;
    logic        m_err   = 1'b0;
    logic        m_vo    = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic model_reset();
        q0.delete();
        q1.delete();
        exp_q.delete();
        m_state = 0;
        m_sel   = 0;
        m_cnt   = 0;
        m_done  = 1'b0;
        m_err   = 1'b0;
        m_vo    = 1'b0;
    endtask

    task automatic emit(input logic [15:0] w);
        exp_t e;
        m_vo = 1'b1;
        m_cnt++;
        m_sel = 1 - m_sel;
        if (m_cnt == m_max) begin
            m_state = 2;
            m_done  = 1'b1;
        end
        e.data = w;
        e.done = m_done;
        exp_q.push_back(e);
    endtask

    // One clock of the reference behaviour, evaluated with the inputs seen at the edge.
    task automatic model_step();
        m_vo = 1'b0;
        if (start) begin
            q0.delete();
            q1.delete();
            m_cnt   = 0;
            m_sel   = 0;
            m_err   = 1'b0;
            m_max   = int'(max);
            m_done  = (max == 8'd0);
            m_state = (max == 8'd0) ? 2 : 1;
        end else if (m_state == 1) begin
            if (m_sel == 0 && q0.size() > 0) emit(q0.pop_front());
            else if (m_sel == 1 && q1.size() > 0) emit(q1.pop_front());
            if (data_in0[16]) begin
                if (q0.size() < DEPTH) q0.push_back(data_in0[15:0]);
                else m_err = 1'b1;
            end
            if (data_in1[16]) begin
                if (q1.size() < DEPTH) q1.push_back(data_in1[15:0]);
                else m_err = 1'b1;
            end
        end
    endtask

    task automatic step(input int st, input int mx, input int v0, input int p0,
                        input int v1, input int p1);
        start    = st[0];
        max      = mx[7:0];
        data_in0 = {v0[0], p0[15:0]};
        data_in1 = {v1[0], p1[15:0]};
        @(posedge clk);
        model_step();
        #1;
        check("valid_out", 32'(valid_out), 32'(m_vo));
        check("done", 32'(done), 32'(m_done));
        check("err", 32'(err), 32'(m_err));
        start    = 1'b0;
        data_in0 = 17'd0;
        data_in1 = 17'd0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0);
    endtask

    task automatic rst_pulse();
        @(negedge clk);
        #1;
        reset_n = 1'b0;
        #1;
        check("reset_immediate", 32'({data_out, valid_out, done, err}), 32'd0);
        model_reset();
        @(posedge clk);
        #1;
        check("reset_held", 32'({data_out, valid_out, done, err}), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        check("after_release", 32'({data_out, valid_out, done, err}), 32'd0);
    endtask

    always @(negedge clk) begin
        if (reset_n) begin
            if (valid_out) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_word: got %0h expected none", data_out);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("data_out", 32'(data_out), 32'(mon_e.data));
                    check("done_with_word", 32'(done), 32'(mon_e.done));
                end
            end else begin
                check("data_idle_zero", 32'(data_out), 32'd0);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        #1;
        check("reset_state", 32'({data_out, valid_out, done, err}), 32'd0);
        @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        // Ordered alternating stream.
        step(1, 4, 0, 0, 0, 0);
        step(0, 0, 1, 16'hA000, 0, 0);
        step(0, 0, 0, 0, 1, 16'hB001);
        step(0, 0, 1, 16'hA002, 0, 0);
        step(0, 0, 0, 0, 1, 16'hB003);
        idle(3);
        check("t30_done", 32'(done), 32'd1);

        // Lane 1 arrives first; output waits for lane 0.
        step(1, 4, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1, 16'hB001);
        idle(1);
        step(0, 0, 1, 16'hA000, 0, 0);
        idle(3);
        check("t31_not_done", 32'(done), 32'd0);

        // Zero-length transfer; words in DONE are discarded.
        step(1, 0, 0, 0, 0, 0);
        check("t32_done", 32'(done), 32'd1);
        step(0, 0, 1, 16'h1234, 1, 16'h5678);
        idle(2);

        // Lane 0 fills while lane 1 is silent; sixth word overflows.
        step(1, 20, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) step(0, 0, 1, 16'hC000 + i, 0, 0);
        check("t33_no_err", 32'(err), 32'd0);
        step(0, 0, 1, 16'hC005, 0, 0);
        check("t33_err", 32'(err), 32'd1);
        idle(3);
        check("t33_err_sticky", 32'(err), 32'd1);

        // Reset mid-transfer, then a fresh short transfer.
        step(1, 6, 0, 0, 0, 0);
        step(0, 0, 1, 16'h0001, 0, 0);
        step(0, 0, 0, 0, 1, 16'h0002);
        step(0, 0, 1, 16'h0003, 0, 0);
        step(0, 0, 0, 0, 1, 16'h0004);
        rst_pulse();
        step(1, 2, 0, 0, 0, 0);
        step(0, 0, 1, 16'h0011, 0, 0);
        step(0, 0, 0, 0, 1, 16'h0022);
        idle(2);
        check("t34_done", 32'(done), 32'd1);

        // Restart while running.
        step(1, 3, 0, 0, 0, 0);
        step(0, 0, 1, 16'h0100, 0, 0);
        step(0, 0, 0, 0, 1, 16'h0201);
        step(1, 2, 0, 0, 0, 0);
        step(0, 0, 1, 16'h0300, 0, 0);
        step(0, 0, 0, 0, 1, 16'h0301);
        idle(2);
        check("t35_done", 32'(done), 32'd1);

        // Longest transfer must finish without counter wrap.
        step(1, 255, 0, 0, 0, 0);
        for (int c = 0; c < 300; c++) step(0, 0, int'(c % 2 == 0), c, int'(c % 2 == 1), c + 16'h8000);
        check("max255_done", 32'(done), 32'd1);
        check("max255_no_err", 32'(err), 32'd0);

        // Randomised transfers with occasional aborts and overflow.
        for (int t = 0; t < 12; t++) begin
            step(1, int'($urandom_range(0, 12)), 0, 0, 0, 0);
            for (int c = 0; c < 40; c++) begin
                step(int'($urandom_range(0, 59) == 0), int'($urandom_range(0, 8)),
                     int'($urandom_range(0, 1)), int'($urandom),
                     int'($urandom_range(0, 1)), int'($urandom));
            end
        end

        @(negedge clk);
        #1;
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
